viterbi_run_sequencer: RTL

- Controller that sequences the Viterbi core's static/global-history datapath.
- Issues `run` strobes by accepting B_LEN-sample groups from the upstream equalizer via valid/ready.
- Tracks warm-up until the static history is meaningful and flags `final_symbols` valid.
- Freezes the core so `est_channel` can be swapped safely, and issues restart clears on flush or channel change.

---
 rtl/viterbi_run_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/viterbi_run_sequencer.sv
// viterbi_run_sequencer
//   Sequences the Viterbi core's static/global-history datapath. Accepts
//   B_LEN-sample groups from the equalizer over valid/ready and turns each
//   accepted group into a `run` strobe for the core. After a restart it
//   counts WARMUP runs before flagging `final_symbols` valid, freezes the
//   core while `est_channel` is swapped, and pulses `core_clr` whenever the
//   core's metrics must be rebuilt (enable, flush, channel change).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   enable              level, sequencer active
//   flush               single-cycle restart request
//   in_valid/in_ready   upstream group handshake
//   run                 core advance strobe (in_valid & in_ready)
//   core_clr            one-cycle clear of core energies/histories
//   out_valid           core `final_symbols` valid this cycle
//   chan_upd_req/ack    channel-estimate update handshake
//   seq_state           IDLE=0, WARM=1, RUN=2, HOLD=3
//   run_count           accepted groups (stats)
//   stall_count         in_valid & !in_ready cycles in WARM/RUN (stats)
//
// Optional feature
//   VITERBI_SEQ_STATS_EN : when defined, run_count/stall_count are
//   saturating counters cleared only by rst; otherwise both read 0 and no
//   counter flops exist.

module viterbi_run_sequencer #(
    parameter int B_LEN     = 2,
    parameter int SH_DEPTH  = 18,
    parameter int WARMUP    = SH_DEPTH / B_LEN,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 run,
    output logic                 core_clr,
    output logic                 out_valid,
    input  logic                 chan_upd_req,
    output logic                 chan_upd_ack,
    output logic [1:0]           seq_state,
    output logic [CNT_WIDTH-1:0] run_count,
    output logic [CNT_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WARM = 2'd1,
        S_RUN  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

    state_t     state_q, state_d;
    logic [7:0] warm_cnt_q, warm_cnt_d;
    logic       core_clr_q, core_clr_d;
    logic       out_valid_q, out_valid_d;
    logic       ack_q, ack_d;

    logic       in_ready_c;
    logic       run_c;
    logic       warm_last;

    assign warm_last = (warm_cnt_q == WARM_LAST);

    // Ready is purely combinational so a request/flush/disable blocks the
    // group in the same cycle it appears. The core_clr cycle is also
    // blocked: the core is busy clearing and must not advance.
    always_comb begin
        in_ready_c = 1'b0;
        case (state_q)
            S_WARM:  in_ready_c = !chan_upd_req && !flush && !core_clr_q;
            S_RUN:   in_ready_c = !chan_upd_req && !flush;
            default: in_ready_c = 1'b0;
        endcase
        if (!enable) begin
            in_ready_c = 1'b0;
        end
    end

    assign run_c = in_valid && in_ready_c;

    // Next-state logic; priority is !enable > flush > chan_upd_req > normal.
    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        core_clr_d  = 1'b0;
        ack_d       = 1'b0;
        // History updates at the run edge, so symbols appear one cycle later.
        out_valid_d = run_c && ((state_q == S_RUN) || warm_last);

        if (!enable) begin
            state_d    = S_IDLE;
            warm_cnt_d = 8'd0;
        end else if (state_q == S_IDLE) begin
            state_d    = S_WARM;
            warm_cnt_d = 8'd0;
            core_clr_d = 1'b1;
        end else if (flush) begin
            state_d    = S_WARM;
            warm_cnt_d = 8'd0;
            core_clr_d = 1'b1;
        end else if (chan_upd_req) begin
            state_d = S_HOLD;
            ack_d   = 1'b1;
        end else if (state_q == S_HOLD) begin
            // Channel swapped: metrics must be rebuilt on the new estimate.
            state_d    = S_WARM;
            warm_cnt_d = 8'd0;
            core_clr_d = 1'b1;
        end else if ((state_q == S_WARM) && run_c) begin
            if (warm_last) begin
                state_d    = S_RUN;
                warm_cnt_d = 8'd0;
            end else begin
                warm_cnt_d = warm_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            warm_cnt_q  <= 8'd0;
            core_clr_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            core_clr_q  <= core_clr_d;
            out_valid_q <= out_valid_d;
            ack_q       <= ack_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign run       = run_c;
    assign core_clr  = core_clr_q;
    assign out_valid = out_valid_q;
    assign seq_state = state_q;
    // The flop asserts from the first HOLD cycle; gating with the live
    // request drops the ack in the same cycle the requester releases it.
    assign chan_upd_ack = ack_q && chan_upd_req && enable;

`ifdef VITERBI_SEQ_STATS_EN
    logic [CNT_WIDTH-1:0] run_count_q, run_count_d;
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic                 stall_ev;

    always_comb begin
        stall_ev = enable && in_valid && !in_ready_c &&
                   ((state_q == S_WARM) || (state_q == S_RUN));

        run_count_d = run_count_q;
        if (run_c && !(&run_count_q)) begin
            run_count_d = run_count_q + CNT_WIDTH'(1);
        end

        stall_count_d = stall_count_q;
        if (stall_ev && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            run_count_q   <= run_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign run_count   = run_count_q;
    assign stall_count = stall_count_q;
`else
    assign run_count   = '0;
    assign stall_count = '0;
`endif

endmodule
